// File: rtl/trivium_out_fifo_if.sv
// Byte stream bus between the Trivium keystream stage, the output buffer
// and the downstream byte consumer.
interface trivium_out_fifo_if #(
    parameter int unsigned DEPTH = 256
);
    logic                     clr;
    logic [7:0]               stream;
    logic                     wt_sgn;
    logic [7:0]               out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               fifo_cnd;
    logic [$clog2(DEPTH):0]   level;
    logic                     ovf;
    logic                     blk_end;

    // Cipher / consumer side
    modport master (
        output clr, stream, wt_sgn, out_ready,
        input  out_data, out_valid, fifo_cnd, level, ovf, blk_end
    );

    // Buffer side
    modport slave (
        input  clr, stream, wt_sgn, out_ready,
        output out_data, out_valid, fifo_cnd, level, ovf, blk_end
    );
endinterface

// File: rtl/trivium_out_fifo.sv
// Output buffer behind the Trivium keystream stage: byte FIFO with a
// registered first-word-fall-through head, block counter and 2-bit status.
module trivium_out_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned BLOCK = 256
) (
    input logic               clk,
    input logic               rst,
    trivium_out_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned BW = $clog2(BLOCK);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLOCK - 1);

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10,
        ST_OVF     = 2'b11
    } state_t;

    logic [7:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] mem_cnt_q, mem_cnt_d;
    logic [LW-1:0] level_q, level_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blk_end_q, blk_end_d;
    state_t        state_q, state_d;

    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          head_free;
    logic          mem_rd;
    logic          mem_we;

    // Datapath: head register loading, memory pointers, occupancy, block count
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        level_d     = level_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        blk_cnt_d   = blk_cnt_q;
        blk_end_d   = 1'b0;

        pop       = out_valid_q && bus.out_ready;
        push_ok   = bus.wt_sgn && ((level_q != FULL_LVL) || pop);
        drop      = bus.wt_sgn && !push_ok;
        head_free = !out_valid_q || pop;
        mem_rd    = head_free && (mem_cnt_q != '0);
        // With memory empty and the head free, the incoming byte is the
        // oldest one, so it goes straight to the head register.
        mem_we    = push_ok && !(head_free && (mem_cnt_q == '0));

        if (head_free) begin
            if (mem_rd) begin
                out_data_d  = mem_q[rd_ptr_q];
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + 1'b1;
            end else if (push_ok) begin
                out_data_d  = bus.stream;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        unique case ({mem_we, mem_rd})
            2'b10:   mem_cnt_d = mem_cnt_q + 1'b1;
            2'b01:   mem_cnt_d = mem_cnt_q - 1'b1;
            default: mem_cnt_d = mem_cnt_q;
        endcase

        unique case ({push_ok, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (push_ok) begin
            blk_cnt_d = blk_cnt_q + 1'b1;
            blk_end_d = (blk_cnt_q == BLK_LAST);
        end

        // Flush wins over any push or pop in the same cycle.
        if (bus.clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_cnt_d   = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
            blk_cnt_d   = '0;
            blk_end_d   = 1'b0;
            mem_we      = 1'b0;
        end
    end

    // Status state machine: next-state from accepted/dropped pushes and level
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = ST_EMPTY;
        end else if (drop) begin
            state_d = ST_OVF;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (push_ok) state_d = ST_PARTIAL;
                end
                ST_PARTIAL: begin
                    if (level_d == FULL_LVL)  state_d = ST_FULL;
                    else if (level_d == '0)   state_d = ST_EMPTY;
                end
                ST_FULL: begin
                    if (pop && !push_ok) state_d = ST_PARTIAL;
                end
                ST_OVF: begin
                    state_d = ST_OVF;
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Control and head registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            mem_cnt_q   <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            blk_cnt_q   <= '0;
            blk_end_q   <= 1'b0;
            state_q     <= ST_EMPTY;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_cnt_q   <= mem_cnt_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            blk_cnt_q   <= blk_cnt_d;
            blk_end_q   <= blk_end_d;
            state_q     <= state_d;
        end
    end

    // Byte storage; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.stream;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.fifo_cnd  = state_q;
    assign bus.level     = level_q;
    assign bus.ovf       = (state_q == ST_OVF);
    assign bus.blk_end   = blk_end_q;
endmodule

// File: tb/tb_trivium_out_fifo.sv
// Directed bench for trivium_out_fifo (DEPTH = BLOCK = 256).
module tb_trivium_out_fifo;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    trivium_out_fifo_if #(.DEPTH(256)) bus ();

    trivium_out_fifo #(.DEPTH(256), .BLOCK(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       clr;
        logic       wt;
        logic [7:0] din;
        logic       rdy;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
        logic [8:0] exp_level;
        logic [1:0] exp_cnd;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [7:0] d, input logic r);
        bus.clr       = c;
        bus.wt_sgn    = w;
        bus.stream    = d;
        bus.out_ready = r;
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic fill_seq(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //             clr  wt   din    rdy  val  chkd  data   lvl   cnd    ovf
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 9'd1, 2'b01, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 9'd2, 2'b01, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 9'd3, 2'b01, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 9'd2, 2'b01, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 9'd1, 2'b01, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 2'b00, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 9'd1, 2'b01, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 1'b1, 8'h66, 9'd1, 2'b01, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h66, 9'd2, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 8'h88, 1'b1, 1'b0, 1'b0, 8'h00, 9'd0, 2'b00, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0, 2'b00, 1'b0};

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        #12;
        chk("rst_out_data", 32'(bus.out_data), 32'h00);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_fifo_cnd", 32'(bus.fifo_cnd), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_blk_end", 32'(bus.blk_end), 32'd0);
        rst = 1'b0;

        // Table: three pushes, three pops, bypass push+pop, flush with push
        for (int unsigned i = 0; i < 11; i++) begin
            drive(vecs[i].clr, vecs[i].wt, vecs[i].din, vecs[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_cnd", i), 32'(bus.fifo_cnd), 32'(vecs[i].exp_cnd));
            chk($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].exp_ovf));
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill to 256, exactly one blk_end after the 256th push
        do_clr();
        for (int unsigned i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 8'(i), 1'b0);
            step();
            chk($sformatf("fill_blk_end_%0d", i), 32'(bus.blk_end), (i == 255) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("full_cnd", 32'(bus.fifo_cnd), 32'b10);
        chk("full_level", 32'(bus.level), 32'd256);
        chk("full_head", 32'(bus.out_data), 32'h00);

        // Dropped push at full
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drop_ovf", 32'(bus.ovf), 32'd1);
        chk("drop_cnd", 32'(bus.fifo_cnd), 32'b11);
        chk("drop_level", 32'(bus.level), 32'd256);
        chk("drop_blk_end", 32'(bus.blk_end), 32'd0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int unsigned i = 0; i < 256; i++) begin
            chk($sformatf("ovf_drain_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("ovf_drain_data_%0d", i), 32'(bus.out_data), 32'(i[7:0]));
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf_drained_level", 32'(bus.level), 32'd0);
        chk("ovf_drained_cnd", 32'(bus.fifo_cnd), 32'b11);
        chk("ovf_drained_valid", 32'(bus.out_valid), 32'd0);
        do_clr();
        chk("clr_cnd", 32'(bus.fifo_cnd), 32'b00);
        chk("clr_ovf", 32'(bus.ovf), 32'd0);

        // Push and pop together at full: accepted, no overflow
        fill_seq(256);
        drive(1'b0, 1'b1, 8'hBB, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("pp_full_ovf", 32'(bus.ovf), 32'd0);
        chk("pp_full_level", 32'(bus.level), 32'd256);
        chk("pp_full_cnd", 32'(bus.fifo_cnd), 32'b10);
        for (int unsigned i = 1; i < 257; i++) begin
            chk($sformatf("pp_drain_data_%0d", i), 32'(bus.out_data),
                (i == 256) ? 32'hBB : 32'(i));
            step();
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pp_drained_level", 32'(bus.level), 32'd0);
        chk("pp_drained_cnd", 32'(bus.fifo_cnd), 32'b00);
        chk("pp_drained_valid", 32'(bus.out_valid), 32'd0);

        // Streaming 300 bytes with ready held high
        do_clr();
        for (int unsigned k = 0; k < 300; k++) begin
            drive(1'b0, 1'b1, 8'(k), 1'b1);
            step();
            chk($sformatf("stream_valid_%0d", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stream_data_%0d", k), 32'(bus.out_data), 32'(k[7:0]));
            chk($sformatf("stream_level_le2_%0d", k), 32'(bus.level <= 9'd2), 32'd1);
            chk($sformatf("stream_blk_end_%0d", k), 32'(bus.blk_end), (k == 255) ? 32'd1 : 32'd0);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        step();
        chk("stream_end_level", 32'(bus.level), 32'd0);
        chk("stream_end_cnd", 32'(bus.fifo_cnd), 32'b00);

        // Asynchronous reset mid-drain at level 100
        do_clr();
        fill_seq(150);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        for (int unsigned i = 0; i < 50; i++) step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 32'd100);
        chk("pre_rst_data", 32'(bus.out_data), 32'd50);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_data", 32'(bus.out_data), 32'h00);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_fifo_cnd", 32'(bus.fifo_cnd), 32'd0);
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_ovf", 32'(bus.ovf), 32'd0);
        chk("arst_blk_end", 32'(bus.blk_end), 32'd0);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h5C, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_data", 32'(bus.out_data), 32'h5C);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        chk("post_rst_cnd", 32'(bus.fifo_cnd), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/trivium_out_fifo.md
# trivium_out_fifo

Output buffer directly downstream of the Trivium keystream stage. It captures each encrypted byte the cipher emits on `stream`/`wt_sgn`, stores up to one full 256-byte block, and drains it to a byte-wide consumer over a valid/ready handshake. It drives the 2-bit `fifo_cnd` status back to the cipher, which holds in its Secret_Ready state until the buffer reports empty.

## Interface
- `DEPTH`, default 256: total byte capacity, counting memory plus output register; power of two, ≥ 4.
- `BLOCK`, default 256: bytes per cipher block, used by the block counter; power of two, ≤ 2^16.
- `clk`  in  1  clock; every flop is updated on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; one clock, no other reset.
- `clr`  in  1  synchronous flush; empties the buffer and clears `ovf`.
- `stream`  in  8  encrypted byte from the cipher.
- `wt_sgn`  in  1  push strobe; one byte is pushed per cycle in which it is high.
- `out_data`  out  8  head byte, registered.
- `out_valid`  out  1  `out_data` holds a valid byte.
- `out_ready`  in  1  consumer accepts the byte; a pop occurs when `out_valid && out_ready`.
- `fifo_cnd`  out  2  status: 00 empty, 01 partial, 10 full, 11 overflow.
- `level`  out  $clog2(DEPTH)+1  bytes held, 0..DEPTH.
- `ovf`  out  1  sticky overflow flag.
- `blk_end`  out  1  one-cycle pulse when the BLOCK-th byte of a block is accepted.

## Operation
- Storage is a DEPTH-entry byte memory with write pointer, read pointer and an occupancy count, plus a registered output stage that presents the head byte (first-word-fall-through).
- Output register loading:
  - The output register loads from memory whenever it is empty, or when it is popped in the same cycle and memory is non-empty.
  - A push into an empty buffer bypasses memory and goes straight into the output register.
- `level` counts bytes in memory plus the output register.
- Push acceptance:
  - A push is accepted if `level < DEPTH`, or if `level == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `ovf` is set.
- Simultaneous push and pop leaves `level` unchanged. Order is preserved in all cases.
- Status state machine (registered, decoded directly to `fifo_cnd`):
  - EMPTY (00) → PARTIAL on an accepted push.
  - PARTIAL (01) → FULL when `level` reaches DEPTH; PARTIAL → EMPTY when `level` reaches 0.
  - FULL (10) → PARTIAL on a pop without a push.
  - Any state → OVF (11) on a dropped push.
  - OVF is left only by `clr` or `rst`, and goes to EMPTY. While in OVF, push and pop keep working and `level` stays accurate.
- Block counter:
  - Width $clog2(BLOCK); counts accepted pushes and wraps at BLOCK.
  - `blk_end` pulses in the cycle after the accepted push that wraps the counter to 0.
- `clr` flushes the buffer:
  - Pointers, `level`, block counter, `out_valid`, `ovf` and `blk_end` go to 0; state goes to EMPTY.
  - `clr` overrides a push or pop in the same cycle. A push in that cycle is discarded without setting `ovf`.
- Pointers wrap modulo DEPTH. `level` never exceeds DEPTH.

## Timing
- Reset values: `out_data` = 0, `out_valid` = 0, `fifo_cnd` = 00, `level` = 0, `ovf` = 0, `blk_end` = 0; all pointers and counters are 0.
- Latency into an empty buffer: push sampled at edge E gives `out_valid` = 1 and `out_data` = that byte after E. Latency is 1 cycle.
- Latency into a non-empty buffer: the byte reaches `out_data` one edge after the byte ahead of it is popped.
- Throughput: one push and one pop per cycle, sustained. With `out_ready` held high, `out_data` streams bytes on consecutive cycles.
- Update timing:
  - `level`, `fifo_cnd` and `ovf` reflect edge E's push/pop after edge E.
  - `fifo_cnd` = 00 appears after the edge that pops the last byte.
- `out_data` is held stable while `out_valid && !out_ready`.
- `rst` asserted mid-transfer clears all state immediately, without waiting for a clock edge. Stored data is lost.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on three consecutive cycles with `out_ready` = 0:
  - `out_valid` = 1 with `out_data` = 0x11 after the first edge.
  - `level` = 3 and `fifo_cnd` = 01.
  - Then raise `out_ready` for 3 cycles: the bytes come out as 0x11, 0x22, 0x33; `level` = 0 and `fifo_cnd` = 00.
- Push 256 bytes 0x00..0xFF with `out_ready` = 0:
  - `fifo_cnd` = 10 and `level` = 256.
  - `blk_end` pulses exactly once, after the 256th push.
- At full, push 0xAA with `out_ready` = 0:
  - `ovf` = 1 and `fifo_cnd` = 11; `level` stays 256.
  - Draining all 256 bytes returns 0x00..0xFF in order, and `fifo_cnd` stays 11.
  - `clr` → `fifo_cnd` = 00.
- At full, push 0xBB and pop in the same cycle:
  - No overflow; `level` stays 256.
  - 0xBB is the last byte drained.
- Continuous streaming with `out_ready` = 1 and one push per cycle for 300 bytes:
  - The output sequence matches the input.
  - `level` ≤ 2 throughout.
  - `blk_end` pulses after push 256.
- Assert `rst` asynchronously mid-drain with `level` = 100:
  - All outputs return to their reset values before the next clock edge.
  - A subsequent push of 0x5C appears on `out_data` one cycle later.
